// File: rtl/issue_pkg.sv
// Shared types for the issue stage: register index, ALU opcode, FSM state.
// Imported by issue_scoreboard and sb_counter_bank.
package issue_pkg;

    typedef logic [4:0] reg_idx_t;
    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_NONE = 4'd0;
    localparam alu_op_t ALU_ADD  = 4'd1;
    localparam alu_op_t ALU_SUB  = 4'd2;
    localparam alu_op_t ALU_MUL  = 4'd3;
    localparam alu_op_t ALU_DIV  = 4'd4;
    localparam alu_op_t ALU_XOR  = 4'd5;
    localparam alu_op_t ALU_AND  = 4'd6;
    localparam alu_op_t ALU_OR   = 4'd7;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } issue_state_t;

    // True when a register event is enabled and targets a tracked register.
    function automatic logic live_idx(input logic en, input reg_idx_t r);
        return en && (r != '0);
    endfunction

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register pending-write counters with saturation and sticky underflow.
// Ports: clk, reset (async active-low); inc_*/wb_*/kill_* events;
// pend (all counters), pend_nz (counter nonzero), err_underflow (sticky).
module sb_counter_bank
    import issue_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               inc_en,
    input  reg_idx_t                           inc_idx,
    input  logic                               wb_en,
    input  reg_idx_t                           wb_idx,
    input  logic                               kill_en,
    input  reg_idx_t                           kill_idx,
    output logic [NUM_REGS-1:0][CNT_W-1:0]     pend,
    output logic [NUM_REGS-1:0]                pend_nz,
    output logic                               err_underflow
);

    localparam int SW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0][CNT_W-1:0] pend_q;
    logic [NUM_REGS-1:0][CNT_W-1:0] pend_d;
    logic [NUM_REGS-1:0]            uflow;
    logic [SW-1:0]                  up;
    logic [SW-1:0]                  dn;

    // All events for a register are summed in a wider domain, then
    // clamped: below zero flags underflow, above max pins at max.
    always_comb begin
        pend_d = pend_q;
        uflow  = '0;
        up     = '0;
        dn     = '0;
        pend_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            up = {{(SW-CNT_W){1'b0}}, pend_q[r]}
               + SW'(inc_en && (inc_idx == reg_idx_t'(r)));
            dn = SW'(wb_en && (wb_idx == reg_idx_t'(r)))
               + SW'(kill_en && (kill_idx == reg_idx_t'(r)));
            if (dn > up) begin
                pend_d[r] = '0;
                uflow[r]  = 1'b1;
            end else if ((up - dn) > SW'(CNT_MAX)) begin
                pend_d[r] = CNT_MAX;
            end else begin
                pend_d[r] = CNT_W'(up - dn);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q        <= '0;
            err_underflow <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (|uflow)
                err_underflow <= 1'b1;
        end
    end

    always_comb begin
        pend_nz = '0;
        for (int r = 0; r < NUM_REGS; r++)
            pend_nz[r] = |pend_q[r];
    end

    assign pend = pend_q;

endmodule

// File: rtl/issue_scoreboard.sv
// Issue stage: RAW/saturation stall, one-entry issue register, flush, fence drain.
// Ports: clk, reset (async active-low); dec_* in (valid/ready); iss_* out
// (valid/ready); wb_valid/wb_rd; flush; fence_req/fence_done; busy;
// err_underflow. Define ISSUE_STALL_STATS_EN for stall_hazard_cnt/stall_bp_cnt.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 2,
    parameter int IMM_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  reg_idx_t         dec_rd,
    input  reg_idx_t         dec_rs1,
    input  reg_idx_t         dec_rs2,
    input  logic             dec_use_rs1,
    input  logic             dec_use_rs2,
    input  logic             dec_reg_write,
    input  alu_op_t          dec_alu_op,
    input  logic [IMM_W-1:0] dec_imm,
    output logic             iss_valid,
    input  logic             iss_ready,
    output reg_idx_t         iss_rd,
    output reg_idx_t         iss_rs1,
    output reg_idx_t         iss_rs2,
    output alu_op_t          iss_alu_op,
    output logic [IMM_W-1:0] iss_imm,
    output logic             iss_reg_write,
    input  logic             wb_valid,
    input  reg_idx_t         wb_rd,
    input  logic             flush,
    input  logic             fence_req,
    output logic             fence_done,
    output logic             busy,
    output logic             err_underflow
`ifdef ISSUE_STALL_STATS_EN
    ,
    output logic [31:0]      stall_hazard_cnt,
    output logic [31:0]      stall_bp_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    issue_state_t state_q;
    issue_state_t state_d;

    logic [NUM_REGS-1:0][CNT_W-1:0] pend;
    logic [NUM_REGS-1:0]            pend_nz;

    logic haz_rs1;
    logic haz_rs2;
    logic haz_sat;
    logic hazard;
    logic slot_free;
    logic accept;
    logic inc_en;
    logic wb_en;
    logic kill_en;

    // Hazards look only at registered counters; a writeback landing this
    // cycle releases the stall on the following cycle.
    assign haz_rs1 = live_idx(dec_use_rs1, dec_rs1) && pend_nz[dec_rs1];
    assign haz_rs2 = live_idx(dec_use_rs2, dec_rs2) && pend_nz[dec_rs2];
    assign haz_sat = live_idx(dec_reg_write, dec_rd)
                   && (pend[dec_rd] == CNT_MAX);
    assign hazard  = haz_rs1 || haz_rs2 || haz_sat;

    assign slot_free = !iss_valid || iss_ready;
    assign dec_ready = (state_q == RUN) && slot_free && !hazard && !flush;
    assign accept    = dec_valid && dec_ready;

    assign inc_en  = accept && live_idx(dec_reg_write, dec_rd);
    assign wb_en   = live_idx(wb_valid, wb_rd);
    // A flushed instruction's write will never retire, so release it here.
    assign kill_en = flush && iss_valid && live_idx(iss_reg_write, iss_rd);

    sb_counter_bank #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) u_bank (
        .clk           (clk),
        .reset         (reset),
        .inc_en        (inc_en),
        .inc_idx       (dec_rd),
        .wb_en         (wb_en),
        .wb_idx        (wb_rd),
        .kill_en       (kill_en),
        .kill_idx      (iss_rd),
        .pend          (pend),
        .pend_nz       (pend_nz),
        .err_underflow (err_underflow)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iss_valid     <= 1'b0;
            iss_rd        <= '0;
            iss_rs1       <= '0;
            iss_rs2       <= '0;
            iss_alu_op    <= ALU_NONE;
            iss_imm       <= '0;
            iss_reg_write <= 1'b0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (accept) begin
            iss_valid     <= 1'b1;
            iss_rd        <= dec_rd;
            iss_rs1       <= dec_rs1;
            iss_rs2       <= dec_rs2;
            iss_alu_op    <= dec_alu_op;
            iss_imm       <= dec_imm;
            iss_reg_write <= dec_reg_write;
        end else if (iss_ready) begin
            iss_valid <= 1'b0;
        end
    end

    assign busy = (|pend_nz) || iss_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        fence_done = 1'b0;
        unique case (state_q)
            RUN: begin
                if (fence_req)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (!busy)
                    state_d = DONE;
            end
            DONE: begin
                fence_done = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase
    end

`ifdef ISSUE_STALL_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_hazard_cnt <= '0;
            stall_bp_cnt     <= '0;
        end else begin
            if (dec_valid && hazard && (state_q == RUN))
                stall_hazard_cnt <= stall_hazard_cnt + 32'd1;
            if (dec_valid && !slot_free && !hazard)
                stall_bp_cnt <= stall_bp_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: hazard vector table, issue-queue
// scoreboard, and directed sequences for stall, flush, same-cycle and fence.
module tb_issue_scoreboard;
    import issue_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             dec_valid;
    logic             dec_ready;
    reg_idx_t         dec_rd, dec_rs1, dec_rs2;
    logic             dec_use_rs1, dec_use_rs2, dec_reg_write;
    alu_op_t          dec_alu_op;
    logic [31:0]      dec_imm;
    logic             iss_valid, iss_ready;
    reg_idx_t         iss_rd, iss_rs1, iss_rs2;
    alu_op_t          iss_alu_op;
    logic [31:0]      iss_imm;
    logic             iss_reg_write;
    logic             wb_valid;
    reg_idx_t         wb_rd;
    logic             flush, fence_req, fence_done, busy, err_underflow;

    int nvec  = 0;
    int nfail = 0;

    typedef struct packed {
        reg_idx_t    rd;
        reg_idx_t    rs1;
        reg_idx_t    rs2;
        alu_op_t     op;
        logic        w;
        logic [31:0] imm;
    } iss_exp_t;

    iss_exp_t q[$];

    typedef struct {
        logic     u1;
        reg_idx_t rs1;
        logic     u2;
        reg_idx_t rs2;
        logic     w;
        reg_idx_t rd;
        logic     fl;
        logic     exp_rdy;
    } vec_t;

    vec_t tbl[12];

    issue_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_rd        (dec_rd),
        .dec_rs1       (dec_rs1),
        .dec_rs2       (dec_rs2),
        .dec_use_rs1   (dec_use_rs1),
        .dec_use_rs2   (dec_use_rs2),
        .dec_reg_write (dec_reg_write),
        .dec_alu_op    (dec_alu_op),
        .dec_imm       (dec_imm),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_rd        (iss_rd),
        .iss_rs1       (iss_rs1),
        .iss_rs2       (iss_rs2),
        .iss_alu_op    (iss_alu_op),
        .iss_imm       (iss_imm),
        .iss_reg_write (iss_reg_write),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .fence_req     (fence_req),
        .fence_done    (fence_done),
        .busy          (busy),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drv(input logic v, input reg_idx_t rd, input reg_idx_t rs1,
                       input reg_idx_t rs2, input logic u1, input logic u2,
                       input logic w, input alu_op_t op,
                       input logic [31:0] imm);
        dec_valid     = v;
        dec_rd        = rd;
        dec_rs1       = rs1;
        dec_rs2       = rs2;
        dec_use_rs1   = u1;
        dec_use_rs2   = u2;
        dec_reg_write = w;
        dec_alu_op    = op;
        dec_imm       = imm;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_NONE, 32'd0);
    endtask

    // Issue-register scoreboard: every accepted instruction must appear on
    // iss_* one cycle later and be consumed in order; flush discards it.
    always @(negedge clk) begin
        iss_exp_t e;
        if (!reset) begin
            q.delete();
        end else begin
            chk("iss_valid_vs_queue", iss_valid, q.size() != 0);
            if (iss_valid && (iss_ready || flush) && q.size() != 0) begin
                e = q.pop_front();
                if (iss_ready && !flush)
                    chk("iss_fields",
                        {iss_rd, iss_rs1, iss_rs2, iss_alu_op,
                         iss_reg_write, iss_imm}, e);
            end
            if (dec_valid && dec_ready)
                q.push_back({dec_rd, dec_rs1, dec_rs2, dec_alu_op,
                             dec_reg_write, dec_imm});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // pend[5]=1 and pend[7]=3 (saturated) when the table is applied
        tbl[0]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 5'd6, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b1};

        reset = 1'b0;
        idle();
        iss_ready = 1'b1;
        wb_valid  = 1'b0;
        wb_rd     = 5'd0;
        flush     = 1'b0;
        fence_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_iss_valid", iss_valid, 1'b0);
        chk("rst_iss_rd", iss_rd, 5'd0);
        chk("rst_iss_imm", iss_imm, 32'd0);
        chk("rst_fence_done", fence_done, 1'b0);
        chk("rst_err", err_underflow, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;
        tick();
        chk("run_ready", dec_ready, 1'b1);

        // setup: one write to x5, three to x7
        drv(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ALU_ADD, 32'h100);
        settle();
        chk("setup_rdy_x5", dec_ready, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ALU_SUB,
                32'h70 + 32'(i));
            settle();
            chk($sformatf("setup_rdy_x7_%0d", i), dec_ready, 1'b1);
            tick();
        end
        idle();
        tick();

        for (int i = 0; i < 12; i++) begin
            drv(1'b0, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].u1,
                tbl[i].u2, tbl[i].w, ALU_NONE, 32'd0);
            flush = tbl[i].fl;
            settle();
            chk($sformatf("tbl_ready[%0d]", i), dec_ready, tbl[i].exp_rdy);
        end
        flush = 1'b0;
        idle();
        tick();

        // saturation: 4th write to x7 waits for one writeback
        drv(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ALU_MUL, 32'h7);
        settle();
        chk("sat_stall", dec_ready, 1'b0);
        tick();
        chk("sat_stall2", dec_ready, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd7;
        settle();
        chk("sat_same_cycle_wb", dec_ready, 1'b0);
        tick();
        wb_valid = 1'b0;
        settle();
        chk("sat_release", dec_ready, 1'b1);
        tick();
        idle();

        // RAW: add x6,x5,x1 waits for wb x5, accepted the cycle after
        drv(1'b1, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, 1'b1, ALU_ADD, 32'd0);
        settle();
        chk("raw_stall", dec_ready, 1'b0);
        tick();
        chk("raw_stall2", dec_ready, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd5;
        settle();
        chk("raw_same_cycle_wb", dec_ready, 1'b0);
        tick();
        wb_valid = 1'b0;
        settle();
        chk("raw_release", dec_ready, 1'b1);
        tick();
        idle();
        tick();

        // backpressure: held instruction stable for 4 cycles
        iss_ready = 1'b0;
        drv(1'b1, 5'd10, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_ADD, 32'h10);
        settle();
        chk("bp_first_accept", dec_ready, 1'b1);
        tick();
        drv(1'b1, 5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_SUB, 32'h20);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("bp_ready[%0d]", i), dec_ready, 1'b0);
            chk($sformatf("bp_op[%0d]", i), iss_alu_op, ALU_ADD);
            chk($sformatf("bp_imm[%0d]", i), iss_imm, 32'h10);
            tick();
        end
        iss_ready = 1'b1;
        settle();
        chk("bp_resume_ready", dec_ready, 1'b1);
        tick();
        chk("bp_no_bubble_valid", iss_valid, 1'b1);
        chk("bp_no_bubble_imm", iss_imm, 32'h20);
        idle();
        tick();

        // same-cycle: accept write x3 with wb x3 while pend[3]=1
        drv(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ALU_XOR, 32'h3);
        tick();
        idle();
        tick();
        drv(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ALU_AND, 32'h33);
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        settle();
        chk("same_cycle_ready", dec_ready, 1'b1);
        tick();
        wb_valid = 1'b0;
        idle();
        tick();
        drv(1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, ALU_NONE, 32'd0);
        settle();
        chk("same_cycle_pend_held", dec_ready, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd3;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("same_cycle_pend_one", dec_ready, 1'b1);
        wb_valid = 1'b1;
        wb_rd    = 5'd0;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("wb_x0_no_err", err_underflow, 1'b0);
        chk("wb_x0_ready", dec_ready, 1'b1);
        idle();

        // retire x6 and the three x7 writes
        wb_valid = 1'b1;
        wb_rd    = 5'd6;
        tick();
        wb_rd = 5'd7;
        repeat (3) tick();
        wb_valid = 1'b0;
        settle();
        chk("all_retired_busy", busy, 1'b0);
        chk("all_retired_err", err_underflow, 1'b0);

        // flush: killed write to x9 releases its counter
        iss_ready = 1'b0;
        drv(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ALU_OR, 32'h9);
        tick();
        drv(1'b1, 5'd12, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_ADD, 32'hc);
        flush = 1'b1;
        settle();
        chk("flush_blocks_ready", dec_ready, 1'b0);
        chk("flush_busy", busy, 1'b1);
        tick();
        flush = 1'b0;
        idle();
        settle();
        chk("flush_iss_valid", iss_valid, 1'b0);
        chk("flush_busy_clear", busy, 1'b0);
        drv(1'b0, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, ALU_NONE, 32'd0);
        settle();
        chk("flush_pend9_zero", dec_ready, 1'b1);
        iss_ready = 1'b1;
        wb_valid  = 1'b1;
        wb_rd     = 5'd9;
        tick();
        wb_valid = 1'b0;
        idle();
        settle();
        chk("underflow_set", err_underflow, 1'b1);

        // fence with two pending writes
        drv(1'b1, 5'd20, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ALU_ADD, 32'h14);
        tick();
        drv(1'b1, 5'd21, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ALU_ADD, 32'h15);
        tick();
        idle();
        tick();
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        drv(1'b1, 5'd22, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, ALU_MUL, 32'h16);
        settle();
        chk("drain_ready", dec_ready, 1'b0);
        chk("drain_busy", busy, 1'b1);
        wb_valid = 1'b1;
        wb_rd    = 5'd20;
        tick();
        chk("drain_ready2", dec_ready, 1'b0);
        chk("drain_no_done", fence_done, 1'b0);
        wb_rd = 5'd21;
        tick();
        wb_valid = 1'b0;
        settle();
        chk("drain_idle_busy", busy, 1'b0);
        chk("drain_idle_done", fence_done, 1'b0);
        chk("drain_idle_ready", dec_ready, 1'b0);
        tick();
        chk("done_pulse", fence_done, 1'b1);
        chk("done_ready", dec_ready, 1'b0);
        tick();
        chk("done_pulse_end", fence_done, 1'b0);
        chk("run_after_fence", dec_ready, 1'b1);
        tick();
        idle();
        tick();

        // reset in the middle of a drain
        drv(1'b1, 5'd25, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, ALU_DIV, 32'h19);
        tick();
        idle();
        tick();
        fence_req = 1'b1;
        tick();
        fence_req = 1'b0;
        settle();
        chk("drain2_ready", dec_ready, 1'b0);
        reset = 1'b0;
        settle();
        chk("rst_drain_done", fence_done, 1'b0);
        chk("rst_drain_busy", busy, 1'b0);
        chk("rst_drain_err", err_underflow, 1'b0);
        chk("rst_drain_valid", iss_valid, 1'b0);
        reset = 1'b1;
        tick();
        drv(1'b0, 5'd0, 5'd25, 5'd0, 1'b1, 1'b0, 1'b0, ALU_NONE, 32'd0);
        settle();
        chk("rst_drain_run_ready", dec_ready, 1'b1);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
